// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit. It latches the fetched instruction into IR, decodes it,
// and steps it through FETCH/DECODE/EXEC/MEM/WB while driving the datapath selects and strobes.
// state  | meaning
// FETCH  | latch instr into IR, no strobes
// DECODE | selects valid from here on; illegal opcode flagged on exit
// EXEC   | ALU step; beq/j/jal/jr/illegal retire here
// MEM    | data memory access; sw retires here
// WB     | register write-back and retire
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [15:0]      imm,
    output logic [25:0]      j_address,
    output logic [2:0]       next_pc_op,
    output logic             pc_write,
    output logic             reg_write,
    output logic             a1_op,
    output logic [1:0]       reg_addr_op,
    output logic [2:0]       reg_data_op,
    output logic [3:0]       alu_op,
    output logic [2:0]       alu_b_op,
    output logic             mem_write,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_SLT, K_SLL, K_JR, K_ORI, K_LUI,
        K_LW, K_LH, K_SW, K_BEQ, K_J, K_JAL, K_ILL
    } kind_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    kind_t            kind;
    logic             pc_write_c, reg_write_c, mem_write_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        kind = K_ILL;
        case (ir_q[31:26])
            6'b000000: begin
                case (ir_q[5:0])
                    6'b100000, 6'b100001: kind = K_ADD;
                    6'b100010, 6'b100011: kind = K_SUB;
                    6'b101010:            kind = K_SLT;
                    6'b000000:            kind = K_SLL;
                    6'b001000:            kind = K_JR;
                    default:              kind = K_ILL;
                endcase
            end
            6'b001101: kind = K_ORI;
            6'b001111: kind = K_LUI;
            6'b100011: kind = K_LW;
            6'b100001: kind = K_LH;
            6'b101011: kind = K_SW;
            6'b000100: kind = K_BEQ;
            6'b000010: kind = K_J;
            6'b000011: kind = K_JAL;
            default:   kind = K_ILL;
        endcase
    end

    // Selects depend only on IR once decoded, so they stay put until the instruction retires.
    always_comb begin
        a1_op       = 1'b0;
        reg_addr_op = 2'd0;
        reg_data_op = 3'd0;
        alu_op      = 4'd0;
        alu_b_op    = 3'd0;
        next_pc_op  = 3'd0;
        if (state_q != S_FETCH) begin
            case (kind)
                K_SUB: alu_op = 4'd1;
                K_SLT: reg_data_op = 3'd5;
                K_SLL: begin
                    a1_op    = 1'b1;
                    alu_op   = 4'd3;
                    alu_b_op = 3'd3;
                end
                K_ORI: begin
                    alu_op      = 4'd2;
                    alu_b_op    = 3'd2;
                    reg_addr_op = 2'd1;
                end
                K_LUI: begin
                    reg_addr_op = 2'd1;
                    reg_data_op = 3'd2;
                end
                K_LW: begin
                    alu_b_op    = 3'd1;
                    reg_addr_op = 2'd1;
                    reg_data_op = 3'd1;
                end
                K_LH: begin
                    alu_b_op    = 3'd1;
                    reg_addr_op = 2'd1;
                    reg_data_op = 3'd4;
                end
                K_SW:  alu_b_op = 3'd1;
                K_BEQ: begin
                    alu_op     = 4'd1;
                    next_pc_op = 3'd1;
                end
                K_J:   next_pc_op = 3'd2;
                K_JAL: begin
                    next_pc_op  = 3'd2;
                    reg_addr_op = 2'd2;
                    reg_data_op = 3'd3;
                end
                K_JR:  next_pc_op = 3'd3;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        illegal_d   = illegal_q;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
                if (kind == K_ILL) illegal_d = 1'b1;
            end
            S_EXEC: begin
                case (kind)
                    K_LW, K_LH, K_SW: state_d = S_MEM;
                    K_BEQ, K_J, K_JR, K_ILL: begin
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end
                    K_JAL: begin
                        pc_write_c  = 1'b1;
                        reg_write_c = 1'b1;
                        state_d     = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (kind == K_SW) begin
                    mem_write_c = 1'b1;
                    pc_write_c  = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (pc_write_c) retired_d = retired_q + CNT_ONE;
    end

    // Reset kills strobes combinationally so an abandoned instruction never writes anything.
    assign pc_write  = pc_write_c  & ~reset;
    assign reg_write = reg_write_c & ~reset;
    assign mem_write = mem_write_c & ~reset;

    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign shamt     = ir_q[10:6];
    assign imm       = ir_q[15:0];
    assign j_address = ir_q[25:0];
    assign state     = state_q;
    assign retired   = retired_q;
    assign illegal   = illegal_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit: the other end of the datapath control interface.
- Latches the fetched instruction into an internal IR, decodes it, and sequences it through FETCH/DECODE/EXEC/MEM/WB.
- Drives the mux selects, ALU op and write enables that the datapath consumes, plus PC/IR update strobes, a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr  in  32  instruction word from IM, valid in FETCH
- rs  out  5  IR[25:21]
- rt  out  5  IR[20:16]
- rd  out  5  IR[15:11]
- shamt  out  5  IR[10:6]
- imm  out  16  IR[15:0]
- j_address  out  26  IR[25:0]
- next_pc_op  out  3  0 pc+4, 1 beq target, 2 j/jal target, 3 rs
- pc_write  out  1  PC update strobe
- reg_write  out  1  GRF write strobe
- a1_op  out  1  1: GRF port1 reads rt (sll)
- reg_addr_op  out  2  0 rd, 1 rt, 2 $31
- reg_data_op  out  3  0 alu, 1 dm, 2 lui, 3 pc+4, 4 lh, 5 slt
- alu_op  out  4  0 add, 1 sub, 2 or, 3 sll (a<<b[4:0])
- alu_b_op  out  3  0 read2, 1 sign-ext imm, 2 zero-ext imm, 3 shamt
- mem_write  out  1  DM write strobe
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB
- retired  out  CNT_W  instructions completed since reset
- illegal  out  1  sticky: unsupported opcode/funct decoded

Behaviour:
- Reset (synchronous, high at posedge):
  - state=FETCH, IR=0, retired=0, illegal=0.
  - While reset is high, pc_write, reg_write and mem_write are forced 0.
  - Reset mid-instruction abandons it: no strobes in the reset cycle, no retire.
- FETCH: IR<=instr at clock edge; next DECODE. All strobes 0.
- Decode from IR (op=IR[31:26], funct=IR[5:0]):
  - R-type op 0: funct 100000/100001 add, 100010/100011 sub, 101010 slt, 000000 sll, 001000 jr.
  - I/J: ori 001101, lui 001111, lw 100011, lh 100001, sw 101011, beq 000100, j 000010, jal 000011.
  - Anything else is illegal.
- Sequences (pc_write asserted exactly once, in the final state; retired increments on that edge):
  - add/sub/slt/sll/ori/lui: FETCH,DECODE,EXEC,WB; reg_write in WB.
  - lw/lh: FETCH,DECODE,EXEC,MEM,WB; reg_write in WB.
  - sw: FETCH,DECODE,EXEC,MEM; mem_write in MEM.
  - beq: FETCH,DECODE,EXEC; pc_write in EXEC with next_pc_op=1.
  - j/jal/jr: FETCH,DECODE,EXEC; pc_write in EXEC with next_pc_op 2/2/3; jal also asserts reg_write in EXEC.
  - Illegal: FETCH,DECODE,EXEC treated as nop (pc+4). illegal<=1 on DECODE→EXEC edge; stays 1 until reset.
- Selects are Moore outputs of (state, IR), held constant from DECODE to the final state:
  - add/addu: alu 0, b 0, addr 0, data 0.
  - sub/subu: alu 1, b 0, addr 0, data 0.
  - slt: b 0, addr 0, data 5.
  - sll: a1_op 1, alu 3, b 3, addr 0, data 0.
  - ori: alu 2, b 2, addr 1, data 0.
  - lui: addr 1, data 2.
  - lw: alu 0, b 1, addr 1, data 1.
  - lh: alu 0, b 1, addr 1, data 4.
  - sw: alu 0, b 1.
  - beq: alu 1, b 0, next_pc_op 1.
  - jal: addr 2, data 3.
  - Unlisted fields are 0; next_pc_op is 0 except as listed.
- Strobes are single-cycle and never asserted in FETCH or DECODE.
- nop (0x00000000) decodes as sll $0; its WB write to $0 is permitted (GRF ignores $0).
- retired wraps from all-ones to 0 without a flag.

Test Plan:
- Reset, then add (0x00221820) → states 0,1,2,4; reg_write and pc_write high only in WB; next_pc_op=0; rd=3; retired=1 after 4 cycles.
- lw (0x8C410004), sw (0xAC410008), lh (0x84410002) → lw 5 cycles (data 1, b 1, addr 1); sw 4 cycles with mem_write only in MEM and reg_write never high; lh data 4; retired=3.
- beq (0x10220003), jal (0x0C000010), jr (0x03E00008) → 3 cycles each; next_pc_op 1, 2, 3 in EXEC; jal reg_write high with addr 2, data 3.
- sll (0x00021080) → a1_op 1, alu 3, b 3, shamt=2; ori (0x34220F0F) → b 2, alu 2.
- Opcode 0xFC000000 → illegal=1 from EXEC on, pc_write with next_pc_op 0, no reg/mem write. A following add still executes; illegal stays 1.
- Reset asserted during MEM of sw → no mem_write in that cycle, next state FETCH, retired=0, illegal=0. Force retired to all-ones via CNT_W=4 and 16 nops → retired wraps to 0.
